// File: rtl/ram_pkg.sv
// Shared constants and types for the byte-enable dual-port RAM.
package ram_pkg;

  localparam int READ_FIRST  = 0;
  localparam int WRITE_FIRST = 1;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-return pipeline: carries data plus valid through LAT register stages.
// Each stage only loads on valid, so the last stage holds its data between reads.
module ram_rd_pipe #(
  parameter int W   = 16,
  parameter int LAT = 1
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         vld_i,
  input  logic [W-1:0] data_i,
  output logic         vld_o,
  output logic [W-1:0] data_o
);

  logic [LAT-1:0]         vld_pipe;
  logic [LAT-1:0][W-1:0]  dat_pipe;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= vld_i;
      if (vld_i) dat_pipe[0] <= data_i;
      for (int k = 1; k < LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        if (vld_pipe[k-1]) dat_pipe[k] <= dat_pipe[k-1];
      end
    end
  end

  assign vld_o  = vld_pipe[LAT-1];
  assign data_o = dat_pipe[LAT-1];

endmodule

// File: rtl/ram_dp_be.sv
// Dual-port RAM: port A read/write with byte enables, port B read-only.
// Contents are zeroed by a self-running INIT sweep after reset, not by the reset itself.
module ram_dp_be
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH   = 4,
  parameter int MEMORY_DEPTH = 16,
  parameter int MEM_WIDTH    = 16,
  parameter int RD_LATENCY   = 1,
  parameter int WR_MODE      = 0
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   A_WrEn,
  input  logic                   A_RdEn,
  input  logic [ADDR_WIDTH-1:0]  A_Address,
  input  logic [MEM_WIDTH-1:0]   A_WrData,
  input  logic [MEM_WIDTH/8-1:0] A_ByteEn,
  output logic [MEM_WIDTH-1:0]   A_RdData,
  output logic                   A_RdValid,
  input  logic                   B_RdEn,
  input  logic [ADDR_WIDTH-1:0]  B_Address,
  output logic [MEM_WIDTH-1:0]   B_RdData,
  output logic                   B_RdValid,
  output logic                   Busy,
  output logic                   AddrErr
);

  localparam int                    NB    = MEM_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH = (ADDR_WIDTH+1)'(MEMORY_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(MEMORY_DEPTH - 1);

  logic [MEM_WIDTH-1:0] mem [MEMORY_DEPTH];

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  addr_err_q, addr_err_d;

  logic                  ready;
  logic                  a_oob, b_oob;
  logic [ADDR_WIDTH-1:0] a_idx, b_idx;
  logic                  a_wr, a_rd, b_rd;
  logic                  a_fwd, b_fwd;
  logic [MEM_WIDTH-1:0]  a_word, b_word, a_merged;
  logic [MEM_WIDTH-1:0]  a_rdata, b_rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      if (cnt_q == LAST) state_d = READY;
      else               cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign ready = (state_q == READY);
  assign Busy  = (state_q == INIT);

  // Out-of-range addresses are clamped to 0 for indexing; their effects are masked below.
  assign a_oob = {1'b0, A_Address} >= DEPTH;
  assign b_oob = {1'b0, B_Address} >= DEPTH;
  assign a_idx = a_oob ? '0 : A_Address;
  assign b_idx = b_oob ? '0 : B_Address;

  assign a_wr = ready & A_WrEn & ~a_oob;
  assign a_rd = ready & A_RdEn;
  assign b_rd = ready & B_RdEn;

  assign a_word = mem[a_idx];
  assign b_word = mem[b_idx];

  always_comb begin
    a_merged = a_word;
    for (int i = 0; i < NB; i++)
      if (A_ByteEn[i]) a_merged[8*i +: 8] = A_WrData[8*i +: 8];
  end

  // WRITE_FIRST: a read hitting this cycle's port A write sees the merged word.
  assign a_fwd = (WR_MODE == WRITE_FIRST) && a_wr;
  assign b_fwd = a_fwd && (B_Address == A_Address);

  assign a_rdata = a_oob ? '0 : (a_fwd ? a_merged : a_word);
  assign b_rdata = b_oob ? '0 : (b_fwd ? a_merged : b_word);

  always_ff @(posedge Clk) begin
    if (state_q == INIT) mem[cnt_q] <= '0;
    else if (a_wr)       mem[a_idx] <= a_merged;
  end

  assign addr_err_d = ready & ((((A_WrEn | A_RdEn) & a_oob)) | (B_RdEn & b_oob));
  assign AddrErr    = addr_err_q;

  ram_rd_pipe #(.W(MEM_WIDTH), .LAT(RD_LATENCY)) u_pipe_a (
    .Clk    (Clk),
    .Rst    (Rst),
    .vld_i  (a_rd),
    .data_i (a_rdata),
    .vld_o  (A_RdValid),
    .data_o (A_RdData)
  );

  ram_rd_pipe #(.W(MEM_WIDTH), .LAT(RD_LATENCY)) u_pipe_b (
    .Clk    (Clk),
    .Rst    (Rst),
    .vld_i  (b_rd),
    .data_i (b_rdata),
    .vld_o  (B_RdValid),
    .data_o (B_RdData)
  );

endmodule

// File: tb/tb_ram_dp_be.sv
// Scoreboard bench for ram_dp_be: two configurations (default, and 5-bit/20-word,
// latency 2, write-first) checked against an array model of the memory rules.
module tb_ram_dp_be;

  localparam int DEP [2] = '{16, 20};
  localparam int LAT [2] = '{1, 2};
  localparam int WM  [2] = '{0, 1};
  localparam int AW  [2] = '{4, 5};

  typedef struct packed {
    logic [15:0] d;
    int unsigned c;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n  [2];
  logic        a_we   [2];
  logic        a_re   [2];
  logic [4:0]  a_addr [2];
  logic [15:0] a_wd   [2];
  logic [1:0]  a_be   [2];
  logic        b_re   [2];
  logic [4:0]  b_addr [2];
  logic [15:0] a_rd   [2];
  logic [15:0] b_rd   [2];
  logic        a_v    [2];
  logic        b_v    [2];
  logic        busy   [2];
  logic        aerr   [2];

  ram_dp_be #(.ADDR_WIDTH(4), .MEMORY_DEPTH(16), .MEM_WIDTH(16), .RD_LATENCY(1), .WR_MODE(0)) u0 (
    .Clk(clk), .Rst(rst_n[0]), .A_WrEn(a_we[0]), .A_RdEn(a_re[0]), .A_Address(a_addr[0][3:0]),
    .A_WrData(a_wd[0]), .A_ByteEn(a_be[0]), .A_RdData(a_rd[0]), .A_RdValid(a_v[0]),
    .B_RdEn(b_re[0]), .B_Address(b_addr[0][3:0]), .B_RdData(b_rd[0]), .B_RdValid(b_v[0]),
    .Busy(busy[0]), .AddrErr(aerr[0]));

  ram_dp_be #(.ADDR_WIDTH(5), .MEMORY_DEPTH(20), .MEM_WIDTH(16), .RD_LATENCY(2), .WR_MODE(1)) u1 (
    .Clk(clk), .Rst(rst_n[1]), .A_WrEn(a_we[1]), .A_RdEn(a_re[1]), .A_Address(a_addr[1]),
    .A_WrData(a_wd[1]), .A_ByteEn(a_be[1]), .A_RdData(a_rd[1]), .A_RdValid(a_v[1]),
    .B_RdEn(b_re[1]), .B_Address(b_addr[1]), .B_RdData(b_rd[1]), .B_RdValid(b_v[1]),
    .Busy(busy[1]), .AddrErr(aerr[1]));

  // Reference model state
  logic [15:0] ref_mem [2][32];
  exp_t        q [4][$];
  logic [15:0] last [4];
  bit          err_at [int unsigned];
  int unsigned rel [2];

  int n_chk  = 0;
  int n_fail = 0;

  // Monitor: sample on the falling edge, pop expected reads as valids appear
  exp_t        m_e;
  logic        m_v, m_eb, m_ee;
  logic [15:0] m_d;
  int          m_i;

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst_n[g]) begin
        n_chk++;
        if (busy[g] !== 1'b1 || a_v[g] !== 1'b0 || b_v[g] !== 1'b0 || aerr[g] !== 1'b0 ||
            a_rd[g] !== 16'h0 || b_rd[g] !== 16'h0) begin
          n_fail++;
          $display("FAIL reset_outputs cfg%0d cyc %0d: busy=%b av=%b bv=%b err=%b ad=%h bd=%h, required busy=1 rest 0",
                   g, cyc, busy[g], a_v[g], b_v[g], aerr[g], a_rd[g], b_rd[g]);
        end
        for (int p = 0; p < 2; p++) begin
          q[2*g+p].delete();
          last[2*g+p] = 16'h0;
        end
      end else begin
        m_eb = (cyc < rel[g] + DEP[g]);
        n_chk++;
        if (busy[g] !== m_eb) begin
          n_fail++;
          $display("FAIL busy cfg%0d cyc %0d: got %b, required %b", g, cyc, busy[g], m_eb);
        end
        m_ee = err_at.exists(cyc*2 + g);
        n_chk++;
        if (aerr[g] !== m_ee) begin
          n_fail++;
          $display("FAIL addr_err cfg%0d cyc %0d: got %b, required %b", g, cyc, aerr[g], m_ee);
        end
        for (int p = 0; p < 2; p++) begin
          m_i = 2*g + p;
          m_v = (p == 0) ? a_v[g] : b_v[g];
          m_d = (p == 0) ? a_rd[g] : b_rd[g];
          n_chk++;
          if (m_v === 1'b1) begin
            if (q[m_i].size() == 0) begin
              n_fail++;
              $display("FAIL spurious_valid cfg%0d port%0d cyc %0d: got valid data %h, required no valid", g, p, cyc, m_d);
            end else begin
              m_e = q[m_i].pop_front();
              if (m_e.c != cyc || m_e.d !== m_d) begin
                n_fail++;
                $display("FAIL read cfg%0d port%0d: got %h at cyc %0d, required %h at cyc %0d", g, p, m_d, cyc, m_e.d, m_e.c);
              end
              last[m_i] = m_e.d;
            end
          end else begin
            if (m_v !== 1'b0 || m_d !== last[m_i]) begin
              n_fail++;
              $display("FAIL hold cfg%0d port%0d cyc %0d: got valid=%b data=%h, required valid=0 data=%h", g, p, cyc, m_v, m_d, last[m_i]);
            end
            if (q[m_i].size() > 0 && q[m_i][0].c <= cyc) begin
              m_e = q[m_i].pop_front();
              n_chk++;
              n_fail++;
              $display("FAIL missing_valid cfg%0d port%0d: got no valid at cyc %0d, required %h", g, p, cyc, m_e.d);
            end
          end
        end
      end
    end
  end

  // One request cycle: drive inputs, then apply the memory rules to the model
  task automatic req(input int g, input bit awe, input bit are, input logic [4:0] aa,
                     input logic [15:0] wd, input logic [1:0] be, input bit bre, input logic [4:0] ba);
    int unsigned c;
    logic [15:0] old, nw, ea, eb;
    bit aoob, boob;
    @(posedge clk); #1;
    a_we[g] = awe; a_re[g] = are; a_addr[g] = aa; a_wd[g] = wd; a_be[g] = be;
    b_re[g] = bre; b_addr[g] = ba;
    c = cyc;
    if (rst_n[g] && c >= rel[g] + DEP[g]) begin
      aoob = (int'(aa) >= DEP[g]);
      boob = (int'(ba) >= DEP[g]);
      old  = aoob ? 16'h0 : ref_mem[g][aa];
      nw   = old;
      for (int i = 0; i < 2; i++)
        if (be[i]) nw[8*i +: 8] = wd[8*i +: 8];
      ea = aoob ? 16'h0 : ((WM[g] == 1 && awe) ? nw : old);
      eb = boob ? 16'h0 : ((WM[g] == 1 && awe && !aoob && ba == aa) ? nw : ref_mem[g][ba]);
      if (are) q[2*g].push_back('{ea, c + LAT[g]});
      if (bre) q[2*g+1].push_back('{eb, c + LAT[g]});
      if (awe && !aoob) ref_mem[g][aa] = nw;
      if (((awe || are) && aoob) || (bre && boob)) err_at[(c+1)*2 + g] = 1'b1;
    end
  endtask

  task automatic rnd(input int g);
    logic [4:0] aa, ba;
    aa = 5'($urandom_range(0, (1 << AW[g]) - 1));
    ba = ($urandom_range(0, 2) == 0) ? aa : 5'($urandom_range(0, (1 << AW[g]) - 1));
    req(g, 1'($urandom), 1'($urandom), aa, 16'($urandom), 2'($urandom), 1'($urandom), ba);
  endtask

  task automatic idle(input int g);
    req(g, 1'b0, 1'b0, 5'd0, 16'h0, 2'b00, 1'b0, 5'd0);
  endtask

  task automatic release_rst(input int g);
    @(posedge clk); #1;
    rst_n[g] = 1'b1;
    rel[g]   = cyc;
    for (int a = 0; a < 32; a++) ref_mem[g][a] = 16'h0;
  endtask

  task automatic assert_rst(input int g);
    @(posedge clk); #1;
    rst_n[g] = 1'b0;
    a_we[g] = 1'b0; a_re[g] = 1'b0; b_re[g] = 1'b0;
  endtask

  task automatic read_all(input int g);
    for (int a = 0; a < DEP[g]; a++) req(g, 1'b0, 1'b1, 5'(a), 16'h0, 2'b00, 1'b1, 5'(a));
  endtask

  task automatic run_cfg(input int g);
    repeat (3) @(posedge clk);
    release_rst(g);
    repeat (DEP[g] - 1) rnd(g);                               // all ignored during INIT
    read_all(g);
    req(g, 1'b1, 1'b0, 5'd3, 16'h1234, 2'b11, 1'b0, 5'd0);
    req(g, 1'b1, 1'b0, 5'd3, 16'hBEEF, 2'b01, 1'b0, 5'd0);
    req(g, 1'b0, 1'b1, 5'd3, 16'h0, 2'b00, 1'b1, 5'd3);      // 0x12EF on both ports
    req(g, 1'b1, 1'b1, 5'd5, 16'hAAAA, 2'b11, 1'b1, 5'd5);   // collision with old 0x0000
    req(g, 1'b0, 1'b1, 5'd1, 16'h0, 2'b00, 1'b0, 5'd0);
    req(g, 1'b0, 1'b1, 5'd2, 16'h0, 2'b00, 1'b0, 5'd0);
    req(g, 1'b0, 1'b1, 5'd3, 16'h0, 2'b00, 1'b0, 5'd0);
    if (g == 1) begin
      req(g, 1'b1, 1'b0, 5'd25, 16'hFFFF, 2'b11, 1'b0, 5'd0);
      req(g, 1'b0, 1'b1, 5'd25, 16'h0, 2'b00, 1'b1, 5'd25);
      read_all(g);
    end
    repeat (200) rnd(g);
    req(g, 1'b0, 1'b1, 5'd7, 16'h0, 2'b00, 1'b1, 5'd7);
    assert_rst(g);
    repeat (3) @(posedge clk);
    release_rst(g);
    repeat (DEP[g] - 1) rnd(g);
    read_all(g);
    repeat (4) idle(g);
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      rst_n[g] = 1'b0; a_we[g] = 1'b0; a_re[g] = 1'b0; a_addr[g] = 5'd0; a_wd[g] = 16'h0;
      a_be[g] = 2'b00; b_re[g] = 1'b0; b_addr[g] = 5'd0; rel[g] = 0;
    end
    for (int i = 0; i < 4; i++) last[i] = 16'h0;
    run_cfg(0);
    run_cfg(1);
    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_dp_be.md
RAM_DP_BE -- requirements
Module: ram_dp_be

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  ADDR_WIDTH 4: address width; MEMORY_DEPTH <= 2**ADDR_WIDTH.
  MEMORY_DEPTH 16: number of words.
  MEM_WIDTH 16: word width; must be a multiple of 8.
  RD_LATENCY 1: read latency in cycles; legal values 1 or 2.
  WR_MODE 0: same-address collision policy; 0 = READ_FIRST, 1 = WRITE_FIRST.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  Clk  in  1  single clock, rising edge.
  Rst  in  1  reset, asynchronous, active-low.
  A_WrEn  in  1  port A write request.
  A_RdEn  in  1  port A read request.
  A_Address  in  ADDR_WIDTH  port A word address.
  A_WrData  in  MEM_WIDTH  port A write data.
  A_ByteEn  in  MEM_WIDTH/8  port A byte write enables.
  A_RdData  out  MEM_WIDTH  port A read data.
  A_RdValid  out  1  port A read data valid, one-cycle pulse.
  B_RdEn  in  1  port B read request (read-only port).
  B_Address  in  ADDR_WIDTH  port B word address.
  B_RdData  out  MEM_WIDTH  port B read data.
  B_RdValid  out  1  port B read data valid, one-cycle pulse.
  Busy  out  1  initialisation in progress.
  AddrErr  out  1  out-of-range access, one-cycle pulse.

Function
REQ-003 The FSM SHALL have two states, INIT and READY; reset forces INIT with the init counter at 0.
REQ-004 In INIT, the block SHALL write zero to the word at the counter address on each clock and increment the counter; after word MEMORY_DEPTH-1 it SHALL enter READY on the next edge; INIT therefore lasts exactly MEMORY_DEPTH cycles.
REQ-005 Busy SHALL be 1 in INIT and 0 in READY; requests presented in INIT SHALL be ignored, producing no Valid pulse and no AddrErr.
REQ-006 In READY, with A_WrEn=1, byte i of mem[A_Address] SHALL be updated from A_WrData only where A_ByteEn[i]=1; A_ByteEn=0 SHALL write nothing.
REQ-007 A_WrEn and A_RdEn asserted together SHALL both be served; read data follows WR_MODE.
REQ-008 For a port A read or port B read at the address written by port A in the same cycle: WR_MODE=0 SHALL return the pre-write word; WR_MODE=1 SHALL return the byte-merged post-write word.
REQ-009 Read latency: RdData and RdValid SHALL update RD_LATENCY rising edges after the request edge; the pipeline SHALL accept one request per cycle per port.
REQ-010 RdData SHALL hold its last value when no read completes; RdValid SHALL pulse for exactly one cycle per accepted read.
REQ-011 Any request with Address >= MEMORY_DEPTH SHALL have its write suppressed; a read SHALL complete with RdData=0 and RdValid=1; AddrErr SHALL pulse one cycle after the request edge (OR of both ports).
REQ-012 Simultaneous port A and port B reads of the same address SHALL both return identical data.

Reset
REQ-013 Asserting Rst SHALL immediately set: A_RdData=0, B_RdData=0, both RdValid=0, AddrErr=0, Busy=1, FSM=INIT, counter=0, all read pipeline stages cleared.
REQ-014 Reset asserted mid-operation SHALL discard in-flight reads without a Valid pulse; a full INIT sequence SHALL follow deassertion.
REQ-015 Memory array contents SHALL NOT be reset asynchronously; zeroing SHALL be done only by INIT.

Structure
REQ-016 Package ram_pkg SHALL hold WR_MODE constants (READ_FIRST=0, WRITE_FIRST=1) and the FSM state type (INIT, READY).
REQ-017 Sub-module ram_rd_pipe, parametrised by width and RD_LATENCY, SHALL carry data plus valid and SHALL be instantiated once per read port.

Verification
REQ-018 Bench SHALL cover the following directed scenarios (default parameters):
  Release Rst -> Busy=1 for 16 cycles then 0; subsequent reads of addresses 0..15 on port B return 0x0000.
  Write A 0x3 <- 0xBEEF with ByteEn=2'b01 over existing 0x1234 -> read returns 0x12EF one cycle later with RdValid pulse.
  Same cycle: A writes 0x5 <- 0xAAAA and B reads 0x5 (old value 0x0000) -> WR_MODE=0 gives B 0x0000; WR_MODE=1 gives B 0xAAAA.
  RD_LATENCY=2, back-to-back reads of 0x1, 0x2, 0x3 -> three consecutive Valid pulses starting 2 cycles after the first request, with data in order.
  ADDR_WIDTH=5, MEMORY_DEPTH=20, write to address 25 -> memory unchanged, AddrErr pulses; a read of 25 returns 0 with Valid.
  Rst asserted one cycle after a read request -> no Valid pulse, outputs 0, Busy=1, INIT restarts.
